// File: rtl/feedback_capture_if.sv
// feedback_capture_if: UART status-byte input and committed feedback outputs.
interface feedback_capture_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       hold;
  logic [7:0] feedback_sig;
  logic       fb_update;
  logic       fb_stale;
  logic       frame_err;
  modport master (output rx_data, rx_valid, hold, input feedback_sig, fb_update, fb_stale, frame_err);
  modport slave  (input rx_data, rx_valid, hold, output feedback_sig, fb_update, fb_stale, frame_err);
endinterface

// File: rtl/feedback_capture.sv
// feedback_capture: debounces tagged feedback frames into a committed kitchen state, deferring commits while hold is high.
// Optional FEEDBACK_PARITY_EN: rx_data[7] is even parity, only bit 6 reserved, feedback_sig[7] forced to 0.
module feedback_capture #(
  parameter int STABLE_CNT   = 2,
  parameter int STALE_CYCLES = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  feedback_capture_if.slave fb
);
  typedef enum logic [1:0] {IDLE, TRACK, PENDING} state_t;
  localparam logic [3:0]  STABLE = 4'(STABLE_CNT);
  localparam logic [23:0] STALE  = 24'(STALE_CYCLES);
  state_t      state_q, state_d;
  logic [7:0]  cand_q, cand_d, pend_q, pend_d, sig_q, sig_d, frame;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] timer_q, timer_d;
  logic        upd_q, upd_d, err_q, err_d;
  logic        is_frame, bad, good, due, commit;
  always_comb begin
    is_frame = fb.rx_valid && fb.rx_data[1:0] == 2'b01;
`ifdef FEEDBACK_PARITY_EN
    bad   = fb.rx_data[6] | (^fb.rx_data);
    frame = {1'b0, fb.rx_data[6:0]};
`else
    bad   = |fb.rx_data[7:6];
    frame = fb.rx_data;
`endif
    good    = is_frame && !bad;
    cand_d  = good ? frame : cand_q;
    cnt_d   = !good ? cnt_q : (frame != cand_q) ? 4'd1 : (cnt_q == STABLE) ? cnt_q : cnt_q + 4'd1;
    due     = good && cnt_d == STABLE && cand_d != sig_q;
    // a fresh due value always wins over an older pending one
    commit  = !fb.hold && (due || state_q == PENDING);
    pend_d  = (fb.hold && due) ? cand_d : pend_q;
    sig_d   = commit ? (due ? cand_d : pend_q) : sig_q;
    upd_d   = commit;
    err_d   = is_frame && bad;
    state_d = commit ? TRACK : (fb.hold && due) ? PENDING : (good && state_q == IDLE) ? TRACK : state_q;
    timer_d = good ? 24'd0 : err_d ? timer_q : (timer_q == STALE) ? timer_q : timer_q + 24'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      pend_q  <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      pend_q  <= pend_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end
  assign fb.feedback_sig = sig_q;
  assign fb.fb_update    = upd_q;
  assign fb.frame_err    = err_q;
  assign fb.fb_stale     = timer_q == STALE;
endmodule

// File: tb/tb_feedback_capture.sv
// tb_feedback_capture: vector table plus stale-timer sequence, checked through an expectation queue.
module tb_feedback_capture;
  typedef struct packed {
    logic       r, v, h;
    logic [7:0] d, sig;
    logic       upd, err;
  } vec_t;
  typedef struct packed {
    logic [7:0] sig;
    logic       upd, err, cs, st;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  feedback_capture_if fb_if ();
  feedback_capture #(.STABLE_CNT(2), .STALE_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .fb(fb_if));
  always #5 clk = ~clk;
`ifndef FEEDBACK_PARITY_EN
  localparam int N = 38;
`else
  localparam int N = 7;
`endif
  vec_t tbl [N];
  task automatic apply(input logic r, v, h, input logic [7:0] d, es, input logic eu, ee, cs, est);
    exp_t e;
    e = '{sig: es, upd: eu, err: ee, cs: cs, st: est};
    sb.push_back(e);
    rst_n = r;
    fb_if.rx_valid = v;
    fb_if.hold = h;
    fb_if.rx_data = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (fb_if.feedback_sig !== e.sig || fb_if.fb_update !== e.upd || fb_if.frame_err !== e.err || (e.cs && fb_if.fb_stale !== e.st)) begin
      n_err++;
      $display("FAIL vec%0d: got sig=%h upd=%b err=%b stale=%b, want sig=%h upd=%b err=%b stale=%b%s",
               n_vec, fb_if.feedback_sig, fb_if.fb_update, fb_if.frame_err, fb_if.fb_stale,
               e.sig, e.upd, e.err, e.st, e.cs ? "" : "(unchecked)");
    end
  endtask
  initial begin
    rst_n = 1'b0;
    fb_if.rx_valid = 1'b0;
    fb_if.hold = 1'b0;
    fb_if.rx_data = 8'h00;
`ifndef FEEDBACK_PARITY_EN
    tbl = '{
      '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h15,1'b1,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h15,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h15,1'b0,1'b0},
      '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h25,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b1,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h3D,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h3D,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b1,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h3D,1'b1,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h3D,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h3D,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h95,8'h3D,1'b0,1'b1},
      '{1'b1,1'b1,1'b0,8'h15,8'h15,1'b1,1'b0},
      '{1'b1,1'b1,1'b0,8'h16,8'h15,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'hD6,8'h15,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h25,8'h15,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h25,8'h25,1'b1,1'b0},
      '{1'b1,1'b1,1'b1,8'h09,8'h25,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h09,8'h25,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h0D,8'h25,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h0D,8'h25,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h0D,1'b1,1'b0},
      '{1'b1,1'b1,1'b1,8'h11,8'h0D,1'b0,1'b0},
      '{1'b1,1'b1,1'b1,8'h11,8'h0D,1'b0,1'b0},
      '{1'b0,1'b0,1'b1,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b0,1'b1,1'b0,8'h15,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h00,1'b0,1'b0},
      '{1'b1,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0}
    };
`else
    tbl = '{
      '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h95,8'h00,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'h95,8'h15,1'b1,1'b0},
      '{1'b1,1'b1,1'b0,8'h15,8'h15,1'b0,1'b1},
      '{1'b1,1'b1,1'b0,8'hBD,8'h15,1'b0,1'b0},
      '{1'b1,1'b1,1'b0,8'hBD,8'h3D,1'b1,1'b0},
      '{1'b1,1'b1,1'b0,8'h55,8'h3D,1'b0,1'b1}
    };
`endif
    for (int i = 0; i < N; i++)
      apply(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].d, tbl[i].sig, tbl[i].upd, tbl[i].err, !tbl[i].r, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++)
      apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, i >= 16);
`ifndef FEEDBACK_PARITY_EN
    apply(1'b1, 1'b1, 1'b0, 8'h95, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    apply(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
